// File: rtl/chunk_serializer.sv
//------------------------------------------------------------------------------
// chunk_serializer : streams one wide chunk out as bytes, byte 0 first
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module chunk_serializer #(
  parameter int num_bits = 512
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                abort,
  input  logic [num_bits-1:0]                 chunk_in,
  input  logic                                chunk_valid,
  output logic                                chunk_ready,
  output logic [7:0]                          host_out,
  output logic                                host_valid,
  input  logic                                host_ready,
  output logic                                host_last,
  output logic [$clog2(num_bits/8)-1:0]       byte_idx,
  output logic                                done_flag
);

  localparam int NUM_BYTES = num_bits / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [num_bits-1:0]   r_shreg;
  logic [IDX_W-1:0]      r_byte_idx;
  logic                  r_done;
  logic                  r_chunk_ready;
  logic                  r_host_valid;
  logic                  r_host_last;

  // chunk_ready is its own register so it stays low through reset and rises
  // on the first edge after release, even though the state is already IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_byte_idx    <= '0;
      r_done        <= 1'b0;
      r_chunk_ready <= 1'b0;
      r_host_valid  <= 1'b0;
      r_host_last   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state       <= S_IDLE;
        r_shreg       <= '0;
        r_byte_idx    <= '0;
        r_chunk_ready <= 1'b1;
        r_host_valid  <= 1'b0;
        r_host_last   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_chunk_ready <= 1'b1;
            if (chunk_valid && r_chunk_ready) begin
              r_state       <= S_SEND;
              r_shreg       <= chunk_in;
              r_byte_idx    <= '0;
              r_chunk_ready <= 1'b0;
              r_host_valid  <= 1'b1;
              r_host_last   <= 1'b0;
            end
          end
          S_SEND: begin
            if (host_ready) begin
              r_shreg <= r_shreg >> 8;
              if (r_host_last) begin
                r_state       <= S_IDLE;
                r_byte_idx    <= '0;
                r_done        <= 1'b1;
                r_chunk_ready <= 1'b1;
                r_host_valid  <= 1'b0;
                r_host_last   <= 1'b0;
              end else begin
                r_byte_idx  <= r_byte_idx + IDX_W'(1);
                r_host_last <= (r_byte_idx + IDX_W'(1)) == c_last_idx;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign chunk_ready = r_chunk_ready;
  assign host_out    = r_shreg[7:0];
  assign host_valid  = r_host_valid;
  assign host_last   = r_host_last;
  assign byte_idx    = r_byte_idx;
  assign done_flag   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_chunk_serializer.sv
//------------------------------------------------------------------------------
// tb_chunk_serializer : directed and random stimulus against a byte-queue model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_chunk_serializer;

  localparam int NUM_BITS = 512;
  localparam int NB       = NUM_BITS / 8;
  localparam int IW       = $clog2(NB);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                abort = 1'b0;
  logic [NUM_BITS-1:0] chunk_in = '0;
  logic                chunk_valid = 1'b0;
  logic                chunk_ready;
  logic [7:0]          host_out;
  logic                host_valid;
  logic                host_ready = 1'b0;
  logic                host_last;
  logic [IW-1:0]       byte_idx;
  logic                done_flag;

  int  n_chk = 0;
  int  n_err = 0;
  int  hr_mode = 0;
  bit  check_en = 1'b0;

  // Reference model: bytes still owed to the host for the current chunk.
  logic [7:0] m_q[$];
  int         m_sent = 0;
  logic       m_cr = 1'b0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  chunk_serializer #(.num_bits(NUM_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .chunk_in    (chunk_in),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .host_out    (host_out),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_last   (host_last),
    .byte_idx    (byte_idx),
    .done_flag   (done_flag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_sent = 0;
        m_cr   = 1'b0;
        m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (abort) begin
          m_q.delete();
          m_sent = 0;
          m_cr   = 1'b1;
        end else if (m_q.size() == 0) begin
          if (m_cr && chunk_valid) begin
            for (int k = 0; k < NB; k++) m_q.push_back(chunk_in[8*k +: 8]);
            m_sent = 0;
            m_cr   = 1'b0;
          end else begin
            m_cr = 1'b1;
          end
        end else if (host_ready) begin
          void'(m_q.pop_front());
          m_sent++;
          if (m_q.size() == 0) begin
            m_done = 1'b1;
            m_sent = 0;
            m_cr   = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("chunk_ready", chunk_ready, m_cr);
      chk("host_valid", host_valid, m_q.size() != 0);
      chk("host_last", host_last, m_q.size() == 1);
      chk("byte_idx", byte_idx, m_sent);
      chk("done_flag", done_flag, m_done);
      if (m_q.size() != 0) chk("host_out", host_out, m_q[0]);
      else if (!rst_n)     chk("host_out_rst", host_out, 8'h00);
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (hr_mode)
        0:       host_ready = 1'b1;
        1:       host_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: host_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [NUM_BITS-1:0] data);
    bit ok = 1'b0;
    chunk_in    = data;
    chunk_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (chunk_ready && !abort) ok = 1'b1;
      step();
    end
    chunk_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (m_q.size() != 0 && cycles < 2000) begin
      step();
      cycles++;
    end
    if (m_q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_sent(input int n);
    int c = 0;
    while (m_sent != n && c < 2000) begin
      step();
      c++;
    end
    if (m_sent != n) chk("sent_timeout", m_sent, n);
  endtask

  initial begin
    logic [NUM_BITS-1:0] seq_chunk;
    logic [NUM_BITS-1:0] rnd_chunk;
    int cyc;

    for (int k = 0; k < NB; k++) seq_chunk[8*k +: 8] = 8'(k + 1);

    // reset held for three cycles
    @(posedge clk);
    #1;
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_chunk_ready", chunk_ready, 0);
      chk("rst_host_valid", host_valid, 0);
      chk("rst_done", done_flag, 0);
      step();
    end
    rst_n = 1'b1;
    chk("rel_chunk_ready_before_edge", chunk_ready, 0);
    step();
    chk("rel_chunk_ready_after_edge", chunk_ready, 1);

    // byte order at full rate
    hr_mode = 0;
    send_chunk(seq_chunk);
    wait_idle(cyc);
    chk("send_cycles", cyc, NB);
    chk("done_pulse", done_flag, 1);
    step();
    chk("done_one_cycle", done_flag, 0);

    // backpressure 1,0,0,1
    hr_mode = 1;
    send_chunk(seq_chunk);
    wait_idle(cyc);
    step();
    hr_mode = 0;

    // back-to-back chunks
    chunk_in    = {NB{8'hAA}};
    chunk_valid = 1'b1;
    cyc = 0;
    while (!chunk_ready && cyc < 20) begin step(); cyc++; end
    step();
    chunk_in = {NB{8'h55}};
    cyc = 0;
    while (cyc < 200) begin
      if (chunk_ready) begin
        chk("b2b_done_at_accept", done_flag, 1);
        step();
        cyc++;
        break;
      end
      step();
      cyc++;
    end
    chunk_valid = 1'b0;
    chk("b2b_gap", cyc, NB + 1);
    wait_idle(cyc);
    step();

    // abort after 10 bytes
    rnd_chunk = seq_chunk ^ {NB{8'hC3}};
    send_chunk(rnd_chunk);
    wait_sent(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_host_valid", host_valid, 0);
    chk("abort_byte_idx", byte_idx, 0);
    chk("abort_done", done_flag, 0);
    step();
    chk("abort_done_later", done_flag, 0);
    abort = 1'b1;
    chunk_valid = 1'b1;
    step();
    abort = 1'b0;
    chunk_valid = 1'b0;
    chk("abort_blocks_accept", host_valid, 0);
    send_chunk(seq_chunk);
    wait_idle(cyc);
    step();

    // asynchronous reset mid-stream
    send_chunk(seq_chunk);
    wait_sent(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_host_valid", host_valid, 0);
    chk("async_rst_chunk_ready", chunk_ready, 0);
    chk("async_rst_host_last", host_last, 0);
    chk("async_rst_host_out", host_out, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    send_chunk(seq_chunk);
    wait_idle(cyc);
    chk("post_rst_cycles", cyc, NB);
    step();

    // randomized traffic
    hr_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      chunk_valid = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < NUM_BITS / 32; w++) chunk_in[32*w +: 32] = $urandom;
      abort = ($urandom_range(0, 199) == 0);
      step();
    end
    abort       = 1'b0;
    chunk_valid = 1'b0;
    hr_mode     = 0;
    wait_idle(cyc);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
